// File: rtl/alu_share_arbiter_pkg.sv
// Shared definitions for the ALU share arbiter: op codes, flag bit
// positions and the arbiter FSM state type.
package alu_pkg;

  localparam logic [2:0] ADD    = 3'd0;
  localparam logic [2:0] SUB    = 3'd1;
  localparam logic [2:0] AND    = 3'd2;
  localparam logic [2:0] LSHIFT = 3'd3;
  localparam logic [2:0] CMP    = 3'd4;

  localparam int unsigned MAX_OP = 4;

  localparam int unsigned ZERO     = 0;
  localparam int unsigned SIGN     = 1;
  localparam int unsigned CMP_FLAG = 2;

  typedef enum logic [1:0] {
    IDLE,
    EXEC,
    RESP
  } state_t;

endpackage

// File: rtl/alu_share_arbiter_if.sv
// One requester channel: request (operands + op) and response (result + flags).
interface alu_share_arbiter_if #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 3
);

  logic              req_valid;
  logic              req_ready;
  logic [DATA_W-1:0] req_a;
  logic [DATA_W-1:0] req_b;
  logic [OP_W-1:0]   req_op;

  logic              rsp_valid;
  logic              rsp_ready;
  logic [DATA_W-1:0] rsp_result;
  logic [2:0]        rsp_flag;

  modport master (
    output req_valid, req_a, req_b, req_op, rsp_ready,
    input  req_ready, rsp_valid, rsp_result, rsp_flag
  );

  modport slave (
    input  req_valid, req_a, req_b, req_op, rsp_ready,
    output req_ready, rsp_valid, rsp_result, rsp_flag
  );

endinterface

// File: rtl/alu_share_arbiter_rr_arb2.sv
// Combinational two-way round-robin grant.
module rr_arb2 (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic grant0,
  output logic grant1
);

  // A lone requester always wins; on a tie the one not served last wins.
  always_comb begin
    grant0 = valid0 & (~valid1 | last_grant);
    grant1 = valid1 & (~valid0 | ~last_grant);
  end

endmodule

// File: rtl/alu_share_arbiter.sv
// Shares one combinational ALU between two requesters. The winner's
// operands are latched and drive the ALU from registers; the ALU output is
// captured one cycle later and returned on the winner's response channel.
module alu_share_arbiter
  import alu_pkg::*;
#(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned OP_W   = 3,
  parameter int unsigned MAX_OP = alu_pkg::MAX_OP
) (
  input  logic              clk,
  input  logic              rst,
  alu_share_arbiter_if.slave ch0,
  alu_share_arbiter_if.slave ch1,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [OP_W-1:0]   alu_op,
  input  logic [DATA_W-1:0] alu_result,
  input  logic [2:0]        alu_flag,
  output logic              illegal_op
);

  localparam logic [OP_W-1:0] MAX_OP_C = OP_W'(MAX_OP);
  localparam logic [OP_W-1:0] CMP_C    = OP_W'(CMP);

  state_t            state;
  logic              last_grant;
  logic              gid;
  logic [DATA_W-1:0] a_q;
  logic [DATA_W-1:0] b_q;
  logic [OP_W-1:0]   op_q;
  logic [DATA_W-1:0] result_q;
  logic [2:0]        flag_q;
  logic              rsp_valid0_q;
  logic              rsp_valid1_q;
  logic              illegal_q;

  logic              grant0;
  logic              grant1;
  logic [DATA_W-1:0] sel_a;
  logic [DATA_W-1:0] sel_b;
  logic [OP_W-1:0]   sel_op;
  logic              rsp_take;

  rr_arb2 u_arb (
    .valid0     (ch0.req_valid),
    .valid1     (ch1.req_valid),
    .last_grant (last_grant),
    .grant0     (grant0),
    .grant1     (grant1)
  );

  // Winner's operands and the granted requester's response acceptance.
  always_comb begin
    sel_a    = grant1 ? ch1.req_a  : ch0.req_a;
    sel_b    = grant1 ? ch1.req_b  : ch0.req_b;
    sel_op   = grant1 ? ch1.req_op : ch0.req_op;
    rsp_take = gid ? ch1.rsp_ready : ch0.rsp_ready;
  end

  assign ch0.req_ready  = (state == IDLE) & grant0;
  assign ch1.req_ready  = (state == IDLE) & grant1;
  assign ch0.rsp_valid  = rsp_valid0_q;
  assign ch1.rsp_valid  = rsp_valid1_q;
  assign ch0.rsp_result = result_q;
  assign ch1.rsp_result = result_q;
  assign ch0.rsp_flag   = flag_q;
  assign ch1.rsp_flag   = flag_q;
  assign alu_a          = a_q;
  assign alu_b          = b_q;
  assign alu_op         = op_q;
  assign illegal_op     = illegal_q;

  // Arbitration FSM with operand, response and pulse registers.
  // illegal_op is registered at acceptance so it is high exactly in EXEC.
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= 1'b1;
      gid          <= 1'b0;
      a_q          <= '0;
      b_q          <= '0;
      op_q         <= '0;
      result_q     <= '0;
      flag_q       <= '0;
      rsp_valid0_q <= 1'b0;
      rsp_valid1_q <= 1'b0;
      illegal_q    <= 1'b0;
    end else begin
      illegal_q <= 1'b0;
      case (state)
        IDLE: begin
          if (grant0 | grant1) begin
            gid       <= grant1;
            a_q       <= sel_a;
            b_q       <= sel_b;
            op_q      <= sel_op;
            illegal_q <= (sel_op > MAX_OP_C);
            state     <= EXEC;
          end
        end
        EXEC: begin
          if (op_q > MAX_OP_C) begin
            result_q <= '0;
            flag_q   <= '0;
          end else if (op_q == CMP_C) begin
            result_q <= '0;
            flag_q   <= alu_flag;
          end else begin
            result_q <= alu_result;
            flag_q   <= alu_flag;
          end
          rsp_valid0_q <= ~gid;
          rsp_valid1_q <= gid;
          state        <= RESP;
        end
        RESP: begin
          if (rsp_take) begin
            rsp_valid0_q <= 1'b0;
            rsp_valid1_q <= 1'b0;
            last_grant   <= gid;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/alu_share_arbiter.md
Name: alu_share_arbiter

Overview:
- Shares the single-cycle combinational ALU between two requesters: req0 (execute stage) and req1 (address/branch helper).
- Arbitrates round-robin and latches the winner's operands to drive the ALU from stable registers.
- Captures result and flags, then returns them on a per-requester valid/ready response channel.
- Sits between the pipeline control and the ALU instance in the RV32 core.

Parameters:
- DATA_W, 32, operand/result width.
- OP_W, 3, ALU op-code width.
- MAX_OP, 4, highest legal op code; CMP is the last legal op.

Ports:
- clk  in  1  single clock for the block.
- rst  in  1  reset; one clock; reset is synchronous and active-high.
- reqN_valid  in  1  request present (N = 0, 1).
- reqN_ready  out  1  request accepted this cycle.
- reqN_a  in  DATA_W  operand A.
- reqN_b  in  DATA_W  operand B.
- reqN_op  in  OP_W  ALU op code.
- alu_a  out  DATA_W  to ALU scrA.
- alu_b  out  DATA_W  to ALU scrB.
- alu_op  out  OP_W  to ALU AluControl.
- alu_result  in  DATA_W  from ALU.
- alu_flag  in  3  from ALU; [0] zero, [1] sign, [2] cmp-equal.
- rspN_valid  out  1  response present.
- rspN_ready  in  1  requester takes response.
- rspN_result  out  DATA_W  result.
- rspN_flag  out  3  flags.
- illegal_op  out  1  one-cycle pulse on an op code > MAX_OP.

Behaviour:
- Op codes: ADD=0, SUB=1, AND=2, LSHIFT=3, CMP=4.
- FSM states: IDLE, EXEC, RESP.
- IDLE:
  - Arbitrate if any reqN_valid.
  - reqN_ready = (state==IDLE) & grant_N. It is combinational from state, both valids and the pointer only.
  - Transfer happens in the same cycle. Latch a, b, op and the grant id into op regs, then go to EXEC.
- Round-robin:
  - A single valid always wins.
  - If both are valid, grant the requester != last_grant.
  - last_grant resets to 1, so req0 wins the first tie.
  - last_grant updates at the response handshake.
- EXEC:
  - alu_a/b/op are driven directly from the op regs.
  - Capture into response regs: result = alu_result, flag = alu_flag. Then go to RESP.
  - CMP: result forced to 0; flag = alu_flag.
  - Illegal op (> MAX_OP): result 0, flag 000, illegal_op = 1 for this cycle only. A response is still delivered.
- RESP:
  - rspG_valid = 1 for the granted requester only. The other rspN_valid = 0.
  - Result and flag hold stable until rspG_ready.
  - On the handshake, return to IDLE. A new grant is possible the following cycle.
  - Both reqN_ready = 0 during EXEC and RESP.
- Latency: request accepted in cycle T; rsp_valid asserted in T+2. Minimum issue interval is 3 cycles.
- alu_a/b/op hold their last latched values in IDLE/RESP; there is no toggling without a new grant.
- Reset values:
  - state = IDLE; last_grant = 1.
  - op regs = 0, so alu_a/b/op = 0.
  - rsp results/flags = 0; all valid/ready outputs = 0; illegal_op = 0.
- Reset mid-operation, in any state: next cycle is IDLE, all outputs take reset values, and the in-flight op is discarded with no response.
- Simultaneous request while in RESP: it is not accepted until the cycle after the response handshake. Requesters must hold reqN_valid and operands stable until ready.

Decomposition:
- Package alu_pkg holds:
  - op-code constants ADD/SUB/AND/LSHIFT/CMP and MAX_OP;
  - flag index constants ZERO=0, SIGN=1, CMP_FLAG=2;
  - the FSM state enum {IDLE, EXEC, RESP}.
- One sub-module, rr_arb2: a combinational 2-way round-robin grant given (valid0, valid1, last_grant) → (grant0, grant1).
- The FSM, op regs and response regs stay in the top module.

Test Plan:
- Single request: req0 ADD a=5, b=7, accepted at T → rsp0_valid at T+2, rsp0_result=12, rsp0_flag[0]=0; rsp1_valid stays 0.
- Tie after reset: req0 SUB 3−3 and req1 AND 0xF0&0x0F both valid → req0 granted first, result 0, flag[0]=1. req1 is granted at the first IDLE cycle after the rsp0 handshake, result 0. A next tie grants req0.
- Back-pressure: req1 LSHIFT 1<<31 with rsp1_ready low for 5 cycles → rsp1_valid held, rsp1_result=0x80000000 stable, req0_ready=0 throughout. Release → IDLE next cycle.
- Compare: req0 CMP a=b=0xDEADBEEF → rsp0_flag[2]=1, rsp0_result=0. Then a=0xDEADBEEF, b=0 → flag[2]=0.
- Illegal op: req1 op=7 → illegal_op high exactly one cycle (EXEC), rsp1_result=0, rsp1_flag=000, response still handshakes.
- Reset in EXEC: assert rst for one cycle → next cycle IDLE, all rsp valids 0, no response for the dropped op. A held req0_valid is accepted (req0_ready=1) in the first cycle after rst deasserts.
